// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage : memory-access pipeline stage placed directly after execute.
//
// Performs LW/LH/LD/SW/SH/SD over a req/ack data-memory bus that may insert
// any number of wait states. Stalls execute (IsStall) while an access is in
// flight. Non-memory instructions pass through with one cycle of latency.
//
// Instruction encoding: opcode lives in IR[WIDTH-1 -: 6].
//   NOP=6'h00  LW=6'h10  LH=6'h11  LD=6'h12  SW=6'h18  SH=6'h19  SD=6'h1A
//
// Ports:
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   IR_in/PC_in/Z_in      instruction, PC and result/store data from execute
//   Addr_in               effective byte address from execute
//   IsStall               high while an access is outstanding
//   IR_out/PC_out/Z_out   instruction, PC and Z to writeback
//   LMD, LMD_hi           loaded data (LMD_hi only non-zero for LD)
//   MemErr                one-cycle pulse on misaligned access (or timeout)
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be   data-memory request side
//   dm_ack/dm_rdata       data-memory response side
//
// Optional build macro: MEM_TIMEOUT_EN
//   Defined  : an access that waits TIMEOUT_CYC cycles without dm_ack is
//              abandoned, MemErr pulses and IR_out becomes NOP.
//   Undefined: the stage waits for dm_ack indefinitely.
// ----------------------------------------------------------------------------
module mem_stage #(
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] IR_in,
   input  logic [WIDTH-3:0] PC_in,
   input  logic [WIDTH-1:0] Z_in,
   input  logic [WIDTH-1:0] Addr_in,
   output logic             IsStall,
   output logic [WIDTH-1:0] IR_out,
   output logic [WIDTH-3:0] PC_out,
   output logic [WIDTH-1:0] Z_out,
   output logic [WIDTH-1:0] LMD,
   output logic [WIDTH-1:0] LMD_hi,
   output logic             MemErr,
   output logic             dm_req,
   output logic             dm_we,
   output logic [WIDTH-1:0] dm_addr,
   output logic [WIDTH-1:0] dm_wdata,
   output logic [3:0]       dm_be,
   input  logic             dm_ack,
   input  logic [WIDTH-1:0] dm_rdata
);

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h10;
   localparam logic [5:0] OP_LH  = 6'h11;
   localparam logic [5:0] OP_LD  = 6'h12;
   localparam logic [5:0] OP_SW  = 6'h18;
   localparam logic [5:0] OP_SH  = 6'h19;
   localparam logic [5:0] OP_SD  = 6'h1A;

   localparam logic [WIDTH-1:0] NOP_IR = {OP_NOP, {(WIDTH-6){1'b0}}};
   localparam int               HW     = WIDTH / 2;

   typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

   function automatic logic is_mem(input logic [5:0] op);
      return op inside {OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return op inside {OP_SW, OP_SH, OP_SD};
   endfunction

   function automatic logic is_half(input logic [5:0] op);
      return op inside {OP_LH, OP_SH};
   endfunction

   function automatic logic is_dbl(input logic [5:0] op);
      return op inside {OP_LD, OP_SD};
   endfunction

   function automatic logic aligned(input logic [5:0] op, input logic [2:0] a);
      logic ok;
      if (is_dbl(op))       ok = (a == 3'b000);
      else if (is_half(op)) ok = ~a[0];
      else                  ok = (a[1:0] == 2'b00);
      return ok;
   endfunction

   // Pick the halfword lane chosen by Addr[1] and sign-extend it.
   function automatic logic [WIDTH-1:0] half_sext(input logic [WIDTH-1:0] w,
                                                  input logic             hi);
      logic [HW-1:0] h;
      h = hi ? w[WIDTH-1:HW] : w[HW-1:0];
      return {{HW{h[HW-1]}}, h};
   endfunction

   state_t           state, state_nxt;
   logic [5:0]       op_in, op_p0;
   logic [WIDTH-1:0] ir_p0, z_p0, lmd_lo_p1;
   logic [WIDTH-3:0] pc_p0;
   logic [WIDTH-3:0] waddr_p0;
   logic             lane_p0;
   logic [WIDTH-1:0] word_addr;
   logic             in_idle, pass_thru, start, misalign, last_beat, timeout;

   assign op_in     = IR_in[WIDTH-1 -: 6];
   assign op_p0     = ir_p0[WIDTH-1 -: 6];
   assign in_idle   = (state == IDLE);
   assign pass_thru = in_idle && !is_mem(op_in);
   assign start     = in_idle &&  is_mem(op_in) &&  aligned(op_in, Addr_in[2:0]);
   assign misalign  = in_idle &&  is_mem(op_in) && !aligned(op_in, Addr_in[2:0]);
   // LD/SD complete on the second beat; single-beat ops on the first.
   assign last_beat = dm_ack && ((state == ACC2) ||
                                 ((state == ACC1) && !is_dbl(op_p0)));

`ifdef MEM_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] wait_cnt;

   // Counts consecutive un-acked cycles of the current beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                wait_cnt <= '0;
      else if (in_idle || dm_ack) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + CNT_W'(1);
   end

   assign timeout = !in_idle && !dm_ack && (wait_cnt == CNT_LAST);
`else
   assign timeout = 1'b0;

   // TIMEOUT_CYC only matters when the timeout is built in.
   if (TIMEOUT_CYC < 1) begin : g_timeout_param_unused
   end
`endif

   // ---- control: state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = ACC1;
         ACC1: begin
            if (dm_ack)       state_nxt = is_dbl(op_p0) ? ACC2 : IDLE;
            else if (timeout) state_nxt = IDLE;
         end
         ACC2: if (dm_ack || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- p0: access context captured when a memory op is accepted ----
   always_ff @(posedge clk) begin
      if (start) begin
         ir_p0    <= IR_in;
         pc_p0    <= PC_in;
         z_p0     <= Z_in;
         waddr_p0 <= Addr_in[WIDTH-1:2];
         lane_p0  <= Addr_in[1];
      end
      // ---- p1: low word of an LD held until the second beat returns ----
      if ((state == ACC1) && dm_ack) lmd_lo_p1 <= dm_rdata;
   end

   // ---- bus drive: a function of state and captured context only ----
   assign word_addr = {waddr_p0, 2'b00};
   assign IsStall   = !in_idle;

   always_comb begin
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      dm_be    = 4'b0000;
      if (!in_idle) begin
         dm_req  = 1'b1;
         dm_we   = is_store(op_p0);
         dm_addr = (state == ACC2) ? word_addr + WIDTH'(4) : word_addr;
         dm_be   = is_half(op_p0) ? (lane_p0 ? 4'b1100 : 4'b0011) : 4'b1111;
         if (is_store(op_p0)) begin
            if (is_half(op_p0))     dm_wdata = {z_p0[HW-1:0], z_p0[HW-1:0]};
            else if (state == ACC1) dm_wdata = z_p0;
            // SD second beat: no 64-bit source, high word is zero.
         end
      end
   end

   // ---- writeback outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         IR_out <= NOP_IR;
         PC_out <= '0;
         Z_out  <= '0;
         LMD    <= '0;
         LMD_hi <= '0;
         MemErr <= 1'b0;
      end else begin
         MemErr <= 1'b0;
         if (pass_thru || misalign) begin
            IR_out <= misalign ? NOP_IR : IR_in;
            PC_out <= PC_in;
            Z_out  <= Z_in;
            LMD    <= '0;
            LMD_hi <= '0;
            MemErr <= misalign;
         end else if (last_beat) begin
            IR_out <= ir_p0;
            PC_out <= pc_p0;
            Z_out  <= z_p0;
            LMD    <= '0;
            LMD_hi <= '0;
            case (op_p0)
               OP_LW: LMD <= dm_rdata;
               OP_LH: LMD <= half_sext(dm_rdata, lane_p0);
               OP_LD: begin
                  LMD    <= lmd_lo_p1;
                  LMD_hi <= dm_rdata;
               end
               default: ;
            endcase
         end else if (timeout) begin
            IR_out <= NOP_IR;
            PC_out <= pc_p0;
            Z_out  <= z_p0;
            LMD    <= '0;
            LMD_hi <= '0;
            MemErr <= 1'b1;
         end
      end
   end

endmodule
